spi_frame_decoder: RTL and testbench
====================================

Name: spi_frame_decoder

Overview:
- Sits directly downstream of the SPI byte slave in the clk domain: consumes each completed received byte (data_incoming) and supplies the next byte to shift out (data_outgoing).
- Synchronizes ce0, detects end-of-byte, parses 2-byte command frames (command + data), and owns a small bank of 8-bit control registers used by the counter logic.
- Registers are written and read back over SPI.

Parameters:
NUM_REGS, 4, number of 8-bit registers; legal 1..127; addresses 0..NUM_REGS-1
IDLE_BYTE, 8'hA5, byte presented on data_outgoing when no read data is pending
TIMEOUT_CYCLES, 1000000, clk cycles allowed between command byte and data byte (about 83 ms at 12 MHz)
SYNC_STAGES, 2, ce0 synchronizer depth; minimum 2

Ports:
clk  input  1  system clock; all logic on its rising edge
reset  input  1  synchronous, active-high reset
ce0  input  1  SPI chip enable straight from the pin, asynchronous, idle high
data_incoming  input  8  last byte received by the SPI slave; stable from ce0 rise until next ce0 fall
data_outgoing  output  8  byte the SPI slave loads at the next ce0 fall
regs  output  8*NUM_REGS  flattened register bank; reg i occupies bits [8i+7:8i]
wr_strobe  output  1  one-cycle pulse when a register is written
wr_addr  output  7  address of the last write; valid with wr_strobe
busy  output  1  high while in WAIT_DATA
frame_err  output  1  one-cycle pulse on bad address or timeout

Behaviour:
- Reset values:
  - Synchronizer flops = 1, so no false edge is seen after reset.
  - State = IDLE; regs = 0; data_outgoing = IDLE_BYTE.
  - wr_strobe = 0, wr_addr = 0, busy = 0, frame_err = 0; timeout counter = 0.
- ce0 is passed through SYNC_STAGES flops, then one more flop for edge detection.
- byte_done is a one-cycle pulse on the synchronized rising edge of ce0. data_incoming is sampled in that same cycle.
- Latency: ce0 pin rise to byte_done is SYNC_STAGES+1 clk cycles. Outputs update on the clock edge ending the byte_done cycle.
- Host requirement: ce0 must stay high for at least SYNC_STAGES+3 clk cycles so that data_outgoing settles before the next fall.
- Command byte format: bit7 = W (1 = write, 0 = read); bits[6:0] = addr.
- State IDLE, on byte_done:
  - Latch W and addr.
  - Set data_outgoing = regs[addr] if addr < NUM_REGS, else 8'h00.
  - Clear the timeout counter and go to WAIT_DATA.
- State WAIT_DATA, on byte_done (data byte):
  - Write with addr < NUM_REGS: regs[addr] <= byte; wr_strobe = 1; wr_addr = addr.
  - Write with addr >= NUM_REGS: nothing is written; frame_err = 1.
  - Read with addr >= NUM_REGS: frame_err = 1. Otherwise the data byte is a don't-care.
  - In all cases set data_outgoing = IDLE_BYTE and go to IDLE.
- State WAIT_DATA, no byte_done:
  - The counter increments each cycle.
  - When the counter equals TIMEOUT_CYCLES-1: go to IDLE, data_outgoing = IDLE_BYTE, frame_err = 1.
- Simultaneous byte_done and timeout: the byte wins and is processed normally; no frame_err from the timeout.
- Counter width is $clog2(TIMEOUT_CYCLES+1); it never wraps because it is cleared on leaving WAIT_DATA.
- Reset mid-frame: a partially completed frame is discarded. The next byte_done is treated as a command byte, and the host resyncs by idling for longer than TIMEOUT_CYCLES.
- Reset while ce0 is held low: no byte_done is generated until ce0 next rises.
- A write to a register is visible on regs in the cycle after byte_done. A read always returns the value as of the command byte.

Optional Feature:
- Macro: SPI_FRAME_ERRCNT_EN.
- Defined:
  - An 8-bit saturating error counter increments on every frame_err pulse; it holds at 8'hFF and resets to 0.
  - A read command to addr 7'h7F loads the counter into data_outgoing and does not pulse frame_err.
  - A write to 7'h7F clears the counter; wr_strobe stays 0.
- Not defined:
  - No counter logic exists.
  - 7'h7F behaves as any out-of-range address: returns 8'h00 and pulses frame_err.

Test Plan:
- Reset, then check with no ce0 activity -> data_outgoing = 8'hA5, regs = 0, busy = 0, no strobes for 100 cycles.
- Write frame: bytes 8'h82 then 8'h3C -> wr_strobe for 1 cycle with wr_addr = 2; regs[23:16] = 8'h3C; data_outgoing returns to 8'hA5.
- Read frame after the write: byte 8'h02 -> data_outgoing = 8'h3C before the next ce0 fall; after the dummy byte -> 8'hA5; no frame_err.
- Bad address: 8'h85 then 8'h11 -> frame_err pulse; regs unchanged. Read of 8'h10 -> data_outgoing = 8'h00, then frame_err on the data byte.
- Timeout with TIMEOUT_CYCLES = 50: send 8'h81 and no further byte -> frame_err at cycle 50 after byte_done, busy drops; a following 8'h01 is treated as a command. Also check that a data byte landing exactly on the timeout cycle is written, with no frame_err.
- With SPI_FRAME_ERRCNT_EN: three bad frames, then read of 8'h7F -> data_outgoing = 8'h03; write 8'hFF then 8'h00 -> counter = 0. Check saturation at 8'hFF after 300 errors.

Source files
------------

// File: rtl/spi_frame_decoder.sv
// spi_frame_decoder
// Sits behind an SPI byte slave. Synchronizes the chip enable, turns each
// completed byte into a one-cycle byte_done, and parses 2-byte frames
// (command + data) that write or read a small bank of 8-bit registers.
// Optional build macro: SPI_FRAME_ERRCNT_EN adds a saturating frame error
// counter that is read at address 7'h7F and cleared by writing 7'h7F.
module spi_frame_decoder #(
  parameter int         NUM_REGS       = 4,
  parameter logic [7:0] IDLE_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter int         SYNC_STAGES    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce0,
  input  logic [7:0]            data_incoming,
  output logic [7:0]            data_outgoing,
  output logic [8*NUM_REGS-1:0] regs,
  output logic                  wr_strobe,
  output logic [6:0]            wr_addr,
  output logic                  busy,
  output logic                  frame_err
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    IDLE,
    WAIT_DATA
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   edge_q, edge_d;
  logic                   byte_done;

  state_t                 state_q, state_d;
  logic                   wr_q, wr_d;
  logic [6:0]             addr_q, addr_d;
  logic [7:0]             dout_q, dout_d;
  logic [8*NUM_REGS-1:0]  regs_q, regs_d;
  logic                   wr_strobe_q, wr_strobe_d;
  logic [6:0]             wr_addr_q, wr_addr_d;
  logic                   frame_err_q, frame_err_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic                   cmd_in_range;
  logic                   addr_in_range;
  logic [7:0]             cmd_rd_data;

`ifdef SPI_FRAME_ERRCNT_EN
  logic [7:0]             errcnt_q, errcnt_d;
  logic                   errcnt_clr;
`endif

  // Synchronizer chain for ce0 plus one extra stage for rising-edge detect
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], ce0};
    edge_d    = sync_q[SYNC_STAGES-1];
    byte_done = sync_q[SYNC_STAGES-1] & ~edge_q;
  end

  // Address decode and register read mux for the incoming command byte
  always_comb begin
    cmd_in_range  = int'(data_incoming[6:0]) < NUM_REGS;
    addr_in_range = int'(addr_q) < NUM_REGS;
    cmd_rd_data   = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(data_incoming[6:0]) == i) begin
        cmd_rd_data = regs_q[8*i +: 8];
      end
    end
  end

  // Frame FSM: next state, register writes, outgoing byte and pulses
  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    dout_d      = dout_q;
    regs_d      = regs_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    frame_err_d = 1'b0;
    cnt_d       = cnt_q;
`ifdef SPI_FRAME_ERRCNT_EN
    errcnt_clr  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (byte_done) begin
          wr_d   = data_incoming[7];
          addr_d = data_incoming[6:0];
          dout_d = cmd_in_range ? cmd_rd_data : 8'h00;
`ifdef SPI_FRAME_ERRCNT_EN
          if (!data_incoming[7] && (data_incoming[6:0] == 7'h7F)) begin
            dout_d = errcnt_q;
          end
`endif
          cnt_d   = '0;
          state_d = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (byte_done) begin
          if (addr_in_range) begin
            if (wr_q) begin
              for (int i = 0; i < NUM_REGS; i++) begin
                if (int'(addr_q) == i) begin
                  regs_d[8*i +: 8] = data_incoming;
                end
              end
              wr_strobe_d = 1'b1;
              wr_addr_d   = addr_q;
            end
`ifdef SPI_FRAME_ERRCNT_EN
          end else if (addr_q == 7'h7F) begin
            errcnt_clr = wr_q;
`endif
          end else begin
            frame_err_d = 1'b1;
          end
          dout_d  = IDLE_BYTE;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          frame_err_d = 1'b1;
          dout_d      = IDLE_BYTE;
          cnt_d       = '0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; synchronizer resets high so no false edge
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q      <= '1;
      edge_q      <= 1'b1;
      state_q     <= IDLE;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      dout_q      <= IDLE_BYTE;
      regs_q      <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      frame_err_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync_q      <= sync_d;
      edge_q      <= edge_d;
      state_q     <= state_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      dout_q      <= dout_d;
      regs_q      <= regs_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      frame_err_q <= frame_err_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef SPI_FRAME_ERRCNT_EN
  // Saturating error counter, bumped by every frame_err pulse
  always_comb begin
    errcnt_d = errcnt_q;
    if (errcnt_clr) begin
      errcnt_d = 8'h00;
    end else if (frame_err_d && (errcnt_q != 8'hFF)) begin
      errcnt_d = errcnt_q + 8'h01;
    end
  end

  // Error counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      errcnt_q <= 8'h00;
    end else begin
      errcnt_q <= errcnt_d;
    end
  end
`endif

  assign data_outgoing = dout_q;
  assign regs          = regs_q;
  assign wr_strobe     = wr_strobe_q;
  assign wr_addr       = wr_addr_q;
  assign busy          = (state_q == WAIT_DATA);
  assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_spi_frame_decoder.sv
// Testbench for spi_frame_decoder with a short timeout (50 cycles).
// Register writes are checked through a scoreboard queue; other results are
// compared directly after each directed step.
module tb_spi_frame_decoder;

  localparam int NUM_REGS = 4;
  localparam int TIMEOUT  = 50;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  ce0;
  logic [7:0]            data_incoming;
  logic [7:0]            data_outgoing;
  logic [8*NUM_REGS-1:0] regs;
  logic                  wr_strobe;
  logic [6:0]            wr_addr;
  logic                  busy;
  logic                  frame_err;

  typedef struct {
    logic [6:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t                   exp_q[$];
  wr_t                   mon_e;
  int                    tests = 0;
  int                    fails = 0;
  int                    err_seen = 0;
  int                    exp_err = 0;
  logic [8*NUM_REGS-1:0] exp_regs = '0;

  spi_frame_decoder #(
    .NUM_REGS      (NUM_REGS),
    .IDLE_BYTE     (8'hA5),
    .TIMEOUT_CYCLES(TIMEOUT),
    .SYNC_STAGES   (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ce0          (ce0),
    .data_incoming(data_incoming),
    .data_outgoing(data_outgoing),
    .regs         (regs),
    .wr_strobe    (wr_strobe),
    .wr_addr      (wr_addr),
    .busy         (busy),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One SPI byte: ce0 falls, stays low 4 cycles, rises with the byte, stays high
  task automatic applyStimulus(input logic [7:0] b, input int high_cycles);
    @(negedge clk);
    ce0 = 1'b0;
    repeat (4) @(negedge clk);
    data_incoming = b;
    ce0 = 1'b1;
    repeat (high_cycles) @(negedge clk);
  endtask

  // Record a write the DUT is expected to perform
  task automatic expectWrite(input logic [6:0] a, input logic [7:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
    exp_regs[8*a +: 8] = d;
  endtask

  // Monitor: counts frame_err pulses and scores every write strobe
  always @(negedge clk) begin
    if (!reset) begin
      if (frame_err) err_seen++;
      if (wr_strobe) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_wr_strobe", {25'd0, wr_addr}, 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("wr_addr", {25'd0, wr_addr}, {25'd0, mon_e.addr});
          checkOutput("wr_regs", {24'd0, regs[8*mon_e.addr +: 8]}, {24'd0, mon_e.data});
        end
      end
    end
  end

  initial begin
    int bad_dout;
    int bad_regs;
    int bad_busy;
    int bad_pulse;
    int found;

    reset         = 1'b1;
    ce0           = 1'b1;
    data_incoming = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Idle after reset
    bad_dout = 0; bad_regs = 0; bad_busy = 0; bad_pulse = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (data_outgoing !== 8'hA5) bad_dout++;
      if (regs !== '0) bad_regs++;
      if (busy !== 1'b0) bad_busy++;
      if (wr_strobe !== 1'b0 || frame_err !== 1'b0) bad_pulse++;
    end
    checkOutput("reset_dout", bad_dout, 0);
    checkOutput("reset_regs", bad_regs, 0);
    checkOutput("reset_busy", bad_busy, 0);
    checkOutput("reset_pulses", bad_pulse, 0);

    // Write 0x3C to reg 2
    applyStimulus(8'h82, 5);
    checkOutput("wr_cmd_busy", busy, 1);
    expectWrite(7'd2, 8'h3C);
    applyStimulus(8'h3C, 5);
    checkOutput("wr_regs_all", regs, exp_regs);
    checkOutput("wr_dout_idle", data_outgoing, 8'hA5);
    checkOutput("wr_busy_done", busy, 0);

    // Read reg 2 back
    applyStimulus(8'h02, 5);
    checkOutput("rd_dout", data_outgoing, 8'h3C);
    applyStimulus(8'h55, 5);
    checkOutput("rd_dout_idle", data_outgoing, 8'hA5);
    checkOutput("rd_err_count", err_seen, exp_err);

    // Bad address write and read
    applyStimulus(8'h85, 5);
    applyStimulus(8'h11, 5);
    exp_err++;
    checkOutput("badwr_err_count", err_seen, exp_err);
    checkOutput("badwr_regs", regs, exp_regs);
    applyStimulus(8'h10, 5);
    checkOutput("badrd_dout", data_outgoing, 8'h00);
    applyStimulus(8'h00, 5);
    exp_err++;
    checkOutput("badrd_err_count", err_seen, exp_err);

    // Timeout: command only; ce0 rise to frame_err is 3 + TIMEOUT cycles
    applyStimulus(8'h81, 0);
    found = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (frame_err) begin
        found = i;
        break;
      end
    end
    exp_err++;
    checkOutput("timeout_cycle", found, TIMEOUT + 3);
    checkOutput("timeout_busy", busy, 0);
    checkOutput("timeout_dout", data_outgoing, 8'hA5);
    applyStimulus(8'h01, 5);
    checkOutput("after_timeout_cmd_busy", busy, 1);
    checkOutput("after_timeout_cmd_dout", data_outgoing, 8'h00);
    applyStimulus(8'h00, 5);
    checkOutput("after_timeout_busy", busy, 0);
    checkOutput("timeout_err_count", err_seen, exp_err);

    // Data byte arriving on the exact timeout cycle must win
    applyStimulus(8'h81, 45);
    expectWrite(7'd1, 8'h5A);
    applyStimulus(8'h5A, 5);
    checkOutput("edge_regs", regs, exp_regs);
    checkOutput("edge_err_count", err_seen, exp_err);
    checkOutput("edge_busy", busy, 0);

    // More writes and a read returning value as of the command byte
    expectWrite(7'd0, 8'hC3);
    applyStimulus(8'h80, 5);
    applyStimulus(8'hC3, 5);
    expectWrite(7'd3, 8'h7E);
    applyStimulus(8'h83, 5);
    applyStimulus(8'h7E, 5);
    applyStimulus(8'h03, 5);
    checkOutput("rd3_dout", data_outgoing, 8'h7E);
    applyStimulus(8'hFF, 5);
    checkOutput("regs_all", regs, exp_regs);

    // Reset mid-frame with ce0 held low; next byte is a command
    applyStimulus(8'h83, 5);
    checkOutput("midframe_busy", busy, 1);
    @(negedge clk);
    ce0   = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_regs = '0;
    repeat (10) @(negedge clk);
    checkOutput("rst_low_busy", busy, 0);
    checkOutput("rst_low_dout", data_outgoing, 8'hA5);
    checkOutput("rst_low_regs", regs, exp_regs);
    data_incoming = 8'h03;
    ce0 = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("rst_cmd_busy", busy, 1);
    checkOutput("rst_cmd_dout", data_outgoing, 8'h00);
    applyStimulus(8'h00, 5);
    checkOutput("rst_frame_busy", busy, 0);

`ifdef SPI_FRAME_ERRCNT_EN
    // Error counter: three bad frames then read it back
    for (int i = 0; i < 3; i++) begin
      applyStimulus(8'h85, 5);
      applyStimulus(8'h11, 5);
    end
    exp_err += 3;
    applyStimulus(8'h7F, 5);
    checkOutput("errcnt_rd3", data_outgoing, 8'h03);
    applyStimulus(8'h00, 5);
    checkOutput("errcnt_rd_no_err", err_seen, exp_err);
    applyStimulus(8'hFF, 5);
    applyStimulus(8'h00, 5);
    applyStimulus(8'h7F, 5);
    checkOutput("errcnt_cleared", data_outgoing, 8'h00);
    applyStimulus(8'h00, 5);
    for (int i = 0; i < 300; i++) begin
      applyStimulus(8'h10, 5);
      applyStimulus(8'h00, 5);
    end
    exp_err += 300;
    applyStimulus(8'h7F, 5);
    checkOutput("errcnt_saturated", data_outgoing, 8'hFF);
    applyStimulus(8'h00, 5);
    checkOutput("errcnt_err_count", err_seen, exp_err);
`else
    // Without the counter, 7'h7F is just another bad address
    applyStimulus(8'h7F, 5);
    checkOutput("addr7f_dout", data_outgoing, 8'h00);
    applyStimulus(8'h00, 5);
    exp_err++;
    applyStimulus(8'hFF, 5);
    applyStimulus(8'h00, 5);
    exp_err++;
    checkOutput("addr7f_err_count", err_seen, exp_err);
    checkOutput("addr7f_regs", regs, exp_regs);
`endif

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
